// File: rtl/bishift_seq_8.sv
// Handshaked multi-cycle logical shifter. Applies one power-of-two stage per clock,
// so every request has the same SEL_W-cycle latency regardless of shift amount.
module bishift_seq_8 #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [SEL_W-1:0] s_sel,
  input  logic             right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int CNT_W = (SEL_W > 1) ? $clog2(SEL_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SEL_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] stage_res;
  logic [SEL_W-1:0] sel;
  logic             dir;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_stage;

  // Accept depends on state only, never on out_ready, so in_ready stays a clean flop decode.
  assign accept     = (state == IDLE) && in_valid;
  assign last_stage = (cnt == LAST_STAGE);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:    if (accept)                 state_next = SHIFT;
      SHIFT:   if (last_stage)             state_next = DONE;
      DONE:    if (out_ready)              state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      SHIFT: ;
      DONE:  out_valid = 1'b1;
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Stage cnt shifts by 2**cnt when its select bit is set; otherwise the operand passes through.
  always_comb begin
    stage_res = acc;
    if (sel[cnt]) begin
      stage_res = dir ? (acc >> (1 << cnt)) : (acc << (1 << cnt));
    end
  end

  // Datapath: operands are captured only on accept, result is latched on the final stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sel <= '0;
      dir <= 1'b0;
      cnt <= '0;
      out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc <= data;
            sel <= s_sel;
            dir <= right;
            cnt <= '0;
          end
        end
        SHIFT: begin
          acc <= stage_res;
          if (last_stage) begin
            cnt <= '0;
            out <= stage_res;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bishift_seq_8.sv
// Bench for bishift_seq_8: directed shift vectors, stall, reset abort and
// randomized back-to-back traffic against a plain-arithmetic shift model.
module tb_bishift_seq_8;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;
  localparam int LAT   = SEL_W;
  localparam int ISSUE = SEL_W + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data;
  logic [SEL_W-1:0] s_sel;
  logic             right;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  bishift_seq_8 #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .s_sel     (s_sel),
    .right     (right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
    logic             r;
    logic [WIDTH-1:0] e;
  } vec_t;

  vec_t dir_tbl [6] = '{
    '{8'hA5, 3'b001, 1'b1, 8'h52},
    '{8'hA5, 3'b011, 1'b1, 8'h14},
    '{8'hA5, 3'b101, 1'b0, 8'hA0},
    '{8'hA5, 3'b111, 1'b0, 8'h80},
    '{8'hA5, 3'b000, 1'b1, 8'hA5},
    '{8'hA5, 3'b000, 1'b0, 8'hA5}
  };

  // Reference: a logical shift by the whole amount at once, zero fill.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input int s, input logic r);
    return r ? (d >> s) : (d << s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    data  = WIDTH'($urandom);
    s_sel = SEL_W'($urandom);
    right = 1'($urandom);
  endtask

  // Present a request and hold it until the accept edge; returns just after that edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s,
                      input logic r, output bit ok);
    int n = 0;
    in_valid = 1'b1;
    data     = d;
    s_sel    = s;
    right    = r;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    ok = in_ready;
    step();
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b required 100", {in_ready, out_valid, busy});
    end
    vectors++;
    if (out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_out: got %h required 00", out);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_directed();
    bit ok;
    int lat;
    foreach (dir_tbl[i]) begin
      send(dir_tbl[i].d, dir_tbl[i].s, dir_tbl[i].r, ok);
      vectors++;
      if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL dir%0d_accept: got ok=%0d busy=%b in_ready=%b required 1/1/0",
                 i, ok, busy, in_ready);
      end
      wait_result(lat);
      vectors++;
      if (lat !== LAT) begin
        miscompares++;
        $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, LAT);
      end
      vectors++;
      if (out !== dir_tbl[i].e) begin
        miscompares++;
        $display("FAIL dir%0d_out: got %h required %h", i, out, dir_tbl[i].e);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== dir_tbl[i].e) begin
        miscompares++;
        $display("FAIL dir%0d_release: got rdy=%b vld=%b out=%h required 1/0/%h",
                 i, in_ready, out_valid, out, dir_tbl[i].e);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int lat;
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
    logic             r;
    logic [WIDTH-1:0] e;
    d = WIDTH'($urandom) | 8'h81;
    s = SEL_W'($urandom);
    r = 1'($urandom);
    e = ref_shift(d, int'(s), r);
    send(d, s, r, ok);
    wait_result(lat);
    vectors++;
    if (!ok || lat !== LAT) begin
      miscompares++;
      $display("FAIL stall_latency: got ok=%0d lat=%0d required 1/%0d", ok, lat, LAT);
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      scramble_inputs();
      step();
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== e) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got vld=%b rdy=%b out=%h required 1/0/%h",
                 k, out_valid, in_ready, out, e);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== e) begin
      miscompares++;
      $display("FAIL stall_release: got rdy=%b vld=%b out=%h required 1/0/%h",
               in_ready, out_valid, out, e);
    end
    step();
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_not_queued: got busy=%b vld=%b required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit seen = 1'b0;
    send(8'hFF, 3'd2, 1'b0, ok);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (!ok || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_state: got ok=%0d vld=%b rdy=%b busy=%b out=%h required 1/0/1/0/00",
               ok, out_valid, in_ready, busy, out);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_result: got out_valid seen=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back(input int n_req);
    logic [WIDTH-1:0] exp_q[$];
    int               acc_q[$];
    int               last_acc = -1;
    int               issued   = 0;
    int               c        = 0;
    logic [WIDTH-1:0] e;
    int               a;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((issued < n_req || exp_q.size() > 0) && c < n_req * ISSUE + 50) begin
      if (out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_spurious: got out=%h required no result", out);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          if (out !== e) begin
            miscompares++;
            $display("FAIL b2b_out: got %h required %h", out, e);
          end
          vectors++;
          if (c - a !== LAT) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d required %0d", c - a, LAT);
          end
        end
      end
      if (in_ready && issued < n_req) begin
        in_valid = 1'b1;
        scramble_inputs();
        exp_q.push_back(ref_shift(data, int'(s_sel), right));
        acc_q.push_back(c + 1);
        if (last_acc >= 0) begin
          vectors++;
          if ((c + 1) - last_acc !== ISSUE) begin
            miscompares++;
            $display("FAIL b2b_interval: got %0d required %0d", (c + 1) - last_acc, ISSUE);
          end
        end
        last_acc = c + 1;
        issued++;
      end else begin
        in_valid = (issued < n_req);
        scramble_inputs();
      end
      step();
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (issued != n_req || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain: got issued=%0d pending=%0d required %0d/0",
               issued, exp_q.size(), n_req);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data      = '0;
    s_sel     = '0;
    right     = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_abort();
    test_back_to_back(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
